// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory fetch bus: single-cycle req/ready handshake, word address and returned data.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ready);
    modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ready);
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words over a req/ready bus and hands them to decode.
// Optional FETCH_PERF_CNT_EN adds fetch_count / stall_count performance counters.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic                      clk,
    input  logic                      rst,
    instr_fetch_unit_if.master        imem,
    input  logic                      stall,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    output logic [31:0]               ir,
    output logic [31:0]               ir_pc,
    output logic                      decoder_en,
    output logic                      fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]               fetch_count,
    output logic [31:0]               stall_count
`endif
);

    typedef enum logic [1:0] {FETCH = 2'd0, ISSUE = 2'd1, HALT = 2'd2} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic        redirect_aligned;

    assign redirect_aligned = (redirect_pc[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Redirect outranks stall, which outranks a completing memory response.
    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (redirect_valid) begin
                    state_next = redirect_aligned ? FETCH : HALT;
                end else if (!stall && imem.imem_ready) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (redirect_valid) begin
                    state_next = redirect_aligned ? FETCH : HALT;
                end else if (!stall) begin
                    state_next = FETCH;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        imem.imem_req  = (state == FETCH) && !rst;
        imem.imem_addr = pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            ir         <= NOP_WORD;
            ir_pc      <= RESET_PC;
            decoder_en <= 1'b0;
            fault      <= 1'b0;
        end else if (state != HALT) begin
            if (redirect_valid) begin
                // Any word returning this cycle belongs to the abandoned path.
                ir         <= NOP_WORD;
                decoder_en <= 1'b0;
                if (redirect_aligned) begin
                    pc <= redirect_pc;
                end else begin
                    fault <= 1'b1;
                end
            end else if (!stall) begin
                if (state == FETCH && imem.imem_ready) begin
                    ir         <= imem.imem_rdata;
                    ir_pc      <= pc;
                    decoder_en <= 1'b1;
                end else if (state == ISSUE) begin
                    pc         <= pc + 32'd4;
                    decoder_en <= 1'b0;
                end
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            if (state == ISSUE && decoder_en && !stall && !redirect_valid) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (state == ISSUE && stall) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: accepted fetches are queued and checked when they reach ir.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef struct {
        logic [31:0] word;
        logic [31:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ready = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        decoder_en;
    logic        fault;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    logic issue_due = 1'b0;

    instr_fetch_unit_if bus ();

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h0050_0093;
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    assign bus.imem_ready = ready;
    assign bus.imem_rdata = mem_word(bus.imem_addr);

    instr_fetch_unit #(.RESET_PC(RST_PC), .NOP_WORD(NOP)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (bus),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ir             (ir),
        .ir_pc          (ir_pc),
        .decoder_en     (decoder_en),
        .fault          (fault)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count),
        .stall_count    (stall_count)
`endif
    );

    always #5 clk = ~clk;

    // A completed handshake must appear on ir the following cycle.
    always @(negedge clk) begin
        exp_t e;
        if (issue_due) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_underflow: no expected entry for ir=%h", ir);
            end else begin
                e = sb.pop_front();
                if (ir !== e.word || ir_pc !== e.addr || decoder_en !== 1'b1) begin
                    miscompares++;
                    $display("FAIL sb_issue: ir=%h ir_pc=%h de=%b, required ir=%h ir_pc=%h de=1",
                             ir, ir_pc, decoder_en, e.word, e.addr);
                end
            end
        end
        issue_due = 1'b0;
        if (!rst && bus.imem_req && ready && !redirect_valid && !stall) begin
            e.word = mem_word(bus.imem_addr);
            e.addr = bus.imem_addr;
            sb.push_back(e);
            issue_due = 1'b1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ready = 1'b1;
        cyc();
        @(negedge clk);
        vectors++;
        if (bus.imem_req !== 1'b0 || decoder_en !== 1'b0 || ir !== NOP || ir_pc !== RST_PC || fault !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: req=%b de=%b ir=%h ir_pc=%h fault=%b, required 0 0 %h %h 0",
                     bus.imem_req, decoder_en, ir, ir_pc, fault, NOP, RST_PC);
        end
        cyc(); rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC) begin
            miscompares++;
            $display("FAIL first_fetch: req=%b addr=%h, required 1 %h", bus.imem_req, bus.imem_addr, RST_PC);
        end
        cyc(); @(negedge clk);
        vectors++;
        if (decoder_en !== 1'b1 || ir !== mem_word(RST_PC) || bus.imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL first_issue: de=%b ir=%h req=%b, required 1 %h 0",
                     decoder_en, ir, bus.imem_req, mem_word(RST_PC));
        end
        cyc(); @(negedge clk);
        vectors++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h104) begin
            miscompares++;
            $display("FAIL second_fetch: req=%b addr=%h, required 1 00000104", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_wait_states();
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h8; ready = 1'b0;
        @(negedge clk);
        cyc(); redirect_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) ready = 1'b1;
            @(negedge clk);
            vectors++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8 || decoder_en !== 1'b0) begin
                miscompares++;
                $display("FAIL wait_hold[%0d]: req=%b addr=%h de=%b, required 1 00000008 0",
                         k, bus.imem_req, bus.imem_addr, decoder_en);
            end
            cyc();
        end
        ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (decoder_en !== 1'b1 || ir_pc !== 32'h8) begin
            miscompares++;
            $display("FAIL wait_issue: de=%b ir_pc=%h, required 1 00000008", decoder_en, ir_pc);
        end
    endtask

    task automatic test_stall();
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h40; ready = 1'b1;
        @(negedge clk);
        cyc(); redirect_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin
            miscompares++;
            $display("FAIL stall_fetch: req=%b addr=%h, required 1 00000040", bus.imem_req, bus.imem_addr);
        end
        for (int k = 0; k < 6; k++) begin
            cyc(); stall = (k < 5);
            @(negedge clk);
            vectors++;
            if (ir !== 32'h0050_0093 || ir_pc !== 32'h40 || decoder_en !== 1'b1 || bus.imem_req !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: ir=%h ir_pc=%h de=%b req=%b, required 00500093 00000040 1 0",
                         k, ir, ir_pc, decoder_en, bus.imem_req);
            end
        end
        cyc(); @(negedge clk);
        vectors++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h44 || decoder_en !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_release: req=%b addr=%h de=%b, required 1 00000044 0",
                     bus.imem_req, bus.imem_addr, decoder_en);
        end
    endtask

    task automatic test_redirect_collision();
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h10; ready = 1'b0;
        @(negedge clk);
        cyc(); redirect_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin
            miscompares++;
            $display("FAIL collide_pre: req=%b addr=%h, required 1 00000010", bus.imem_req, bus.imem_addr);
        end
        cyc(); ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        cyc(); ready = 1'b0; redirect_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (ir !== NOP || decoder_en !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin
            miscompares++;
            $display("FAIL collide_discard: ir=%h de=%b req=%b addr=%h, required 00000013 0 1 00000200",
                     ir, decoder_en, bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_misaligned();
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h202;
        @(negedge clk);
        cyc(); redirect_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (fault !== 1'b1 || bus.imem_req !== 1'b0 || decoder_en !== 1'b0 || ir !== NOP) begin
            miscompares++;
            $display("FAIL misalign_fault: fault=%b req=%b de=%b ir=%h, required 1 0 0 00000013",
                     fault, bus.imem_req, decoder_en, ir);
        end
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h300; ready = 1'b1;
        @(negedge clk);
        cyc(); redirect_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (fault !== 1'b1 || bus.imem_req !== 1'b0 || decoder_en !== 1'b0) begin
                miscompares++;
                $display("FAIL halt_frozen[%0d]: fault=%b req=%b de=%b, required 1 0 0",
                         k, fault, bus.imem_req, decoder_en);
            end
            cyc();
        end
        rst = 1'b1; ready = 1'b0;
        @(negedge clk);
        cyc(); rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (fault !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC) begin
            miscompares++;
            $display("FAIL halt_reset: fault=%b req=%b addr=%h, required 0 1 %h",
                     fault, bus.imem_req, bus.imem_addr, RST_PC);
        end
    endtask

    task automatic test_wrap_counter();
`ifdef FETCH_PERF_CNT_EN
        vectors++;
        if (fetch_count !== 32'd0 || stall_count !== 32'd0) begin
            miscompares++;
            $display("FAIL cnt_reset: fetch=%0d stall=%0d, required 0 0", fetch_count, stall_count);
        end
`endif
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; ready = 1'b1;
        @(negedge clk);
        cyc(); redirect_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin
            miscompares++;
            $display("FAIL wrap_fetch0: req=%b addr=%h, required 1 fffffffc", bus.imem_req, bus.imem_addr);
        end
        cyc(); @(negedge clk);
        cyc(); @(negedge clk);
        vectors++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap_fetch1: req=%b addr=%h, required 1 00000000", bus.imem_req, bus.imem_addr);
        end
        cyc(); @(negedge clk);
        cyc(); @(negedge clk);
        vectors++;
        if (bus.imem_addr !== 32'h4) begin
            miscompares++;
            $display("FAIL wrap_fetch2: addr=%h, required 00000004", bus.imem_addr);
        end
`ifdef FETCH_PERF_CNT_EN
        vectors++;
        if (fetch_count !== 32'd2) begin
            miscompares++;
            $display("FAIL fetch_count: got %0d, required 2", fetch_count);
        end
`endif
        for (int k = 0; k < 4; k++) begin
            cyc(); stall = 1'b1;
            @(negedge clk);
        end
        cyc(); stall = 1'b0;
        @(negedge clk);
        vectors++;
        if (decoder_en !== 1'b1 || ir_pc !== 32'h4) begin
            miscompares++;
            $display("FAIL wrap_stall: de=%b ir_pc=%h, required 1 00000004", decoder_en, ir_pc);
        end
`ifdef FETCH_PERF_CNT_EN
        vectors++;
        if (stall_count !== 32'd4 || fetch_count !== 32'd2) begin
            miscompares++;
            $display("FAIL stall_count: stall=%0d fetch=%0d, required 4 2", stall_count, fetch_count);
        end
        cyc(); @(negedge clk);
        vectors++;
        if (fetch_count !== 32'd3) begin
            miscompares++;
            $display("FAIL fetch_count_after: got %0d, required 3", fetch_count);
        end
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_wait_states();
        test_stall();
        test_redirect_collision();
        test_misaligned();
        test_wrap_counter();
        cyc(); ready = 1'b0;
        repeat (3) cyc();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: %0d entries never issued, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
